// File: rtl/bp_be_pkg.sv
// Backend shared types: processor configuration selector and the long-latency
// writeback packet carried through the result buffer.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg,
    e_bp_inv_cfg,
    e_bp_multicore_cfg
  } bp_params_e;

  localparam int rf_addr_width_gp = 5;
  localparam int dword_width_gp   = 64;

  typedef struct packed {
    logic [rf_addr_width_gp-1:0] rd_addr;
    logic [dword_width_gp-1:0]   data;
  } bp_be_long_wb_pkt_s;

  // All current configurations share the 64-bit integer datapath.
  function automatic int bp_be_dword_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg, e_bp_inv_cfg, e_bp_multicore_cfg: return dword_width_gp;
      default: return dword_width_gp;
    endcase
  endfunction

endpackage

`define BP_BE_LONG_WB_PKT_WIDTH ($bits(bp_be_pkg::bp_be_long_wb_pkt_s))

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular FIFO, one write and one read port, ready/valid-yumi handshake.
// Also exposes per-slot valid and tag bits so a caller can search pending entries.
module bsg_fifo_1r1w_small #(
  parameter int width_p     = 69,
  parameter int els_p       = 2,
  parameter int tag_width_p = 5
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic                                  v_i,
  input  logic [width_p-1:0]                    data_i,
  output logic                                  ready_o,
  output logic                                  v_o,
  output logic [width_p-1:0]                    data_o,
  input  logic                                  yumi_i,
  output logic [els_p-1:0]                      slot_v_o,
  output logic [els_p-1:0][tag_width_p-1:0]     slot_tag_o
);

  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_width_lp = $clog2(els_p + 1);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
  localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);

  logic [els_p-1:0][width_p-1:0] mem_q, mem_d;
  logic [ptr_width_lp-1:0]       rptr_q, rptr_d, wptr_q, wptr_d;
  logic [cnt_width_lp-1:0]       cnt_q, cnt_d;
  logic                          enq, deq;

  assign ready_o = (cnt_q != full_cnt_lp);
  assign v_o     = (cnt_q != '0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = mem_q[rptr_q];

  always_comb begin
    mem_d  = mem_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (enq) begin
      mem_d[wptr_q] = data_i;
      wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + 1'b1;
    end
    if (deq) begin
      rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + 1'b1;
    end
    case ({enq, deq})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // A slot is live when its distance from the read pointer is below occupancy.
  always_comb begin
    slot_v_o   = '0;
    slot_tag_o = '0;
    for (int i = 0; i < els_p; i++) begin
      slot_v_o[i]   = (((i >= int'(rptr_q)) ? (i - int'(rptr_q))
                                            : (i + els_p - int'(rptr_q))) < int'(cnt_q));
      slot_tag_o[i] = mem_q[i][width_p-1 -: tag_width_p];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bp_be_long_wb_arbiter.sv
// Shares the integer register file write port between the fixed-latency pipe
// (always wins) and buffered long-latency div/rem results; requests a stall on starvation.
module bp_be_long_wb_arbiter
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p    = e_bp_inv_cfg,
  parameter int         buf_els_p      = 2,
  parameter int         starve_limit_p = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        iwb_v_i,
  input  logic [4:0]  iwb_rd_addr_i,
  input  logic [63:0] iwb_data_i,
  input  logic        long_v_i,
  input  logic [4:0]  long_rd_addr_i,
  input  logic [63:0] long_data_i,
  output logic        long_ready_o,
  output logic        irf_w_v_o,
  output logic [4:0]  irf_w_addr_o,
  output logic [63:0] irf_w_data_o,
  output logic        irf_w_src_o,
  input  logic [4:0]  check_addr_i,
  output logic        check_hit_o,
  output logic        stall_o
);

  localparam int pkt_width_lp    = `BP_BE_LONG_WB_PKT_WIDTH;
  localparam int dword_width_lp  = bp_be_dword_width(bp_params_p);
  localparam int starve_width_lp = $clog2(starve_limit_p + 1);
  localparam logic [starve_width_lp-1:0] starve_max_lp = starve_width_lp'(starve_limit_p);

  bp_be_long_wb_pkt_s                              enq_pkt, head_pkt;
  logic                                            fifo_ready, fifo_v, fifo_enq, fifo_deq;
  logic [buf_els_p-1:0]                            slot_v;
  logic [buf_els_p-1:0][rf_addr_width_gp-1:0]      slot_tag;
  logic [starve_width_lp-1:0]                      starve_cnt_q, starve_cnt_d;
  logic                                            stall_q, stall_d;
  logic [dword_width_lp-1:0]                       w_data;
  logic                                            hit_any;

  // Ready depends only on registered occupancy, so a full buffer never passes through.
  assign long_ready_o = fifo_ready & ~reset_i;
  assign enq_pkt      = '{rd_addr: long_rd_addr_i, data: long_data_i};
  assign fifo_enq     = long_v_i & long_ready_o & (long_rd_addr_i != '0);

  bsg_fifo_1r1w_small #(
    .width_p     (pkt_width_lp),
    .els_p       (buf_els_p),
    .tag_width_p (rf_addr_width_gp)
  ) u_buf (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (fifo_enq),
    .data_i     (enq_pkt),
    .ready_o    (fifo_ready),
    .v_o        (fifo_v),
    .data_o     (head_pkt),
    .yumi_i     (fifo_deq),
    .slot_v_o   (slot_v),
    .slot_tag_o (slot_tag)
  );

  always_comb begin
    irf_w_v_o    = 1'b0;
    irf_w_addr_o = '0;
    w_data       = '0;
    irf_w_src_o  = 1'b0;
    fifo_deq     = 1'b0;
    if (!reset_i) begin
      if (iwb_v_i) begin
        irf_w_v_o    = 1'b1;
        irf_w_addr_o = iwb_rd_addr_i;
        w_data       = iwb_data_i;
      end else if (fifo_v) begin
        irf_w_v_o    = 1'b1;
        irf_w_addr_o = head_pkt.rd_addr;
        w_data       = head_pkt.data;
        irf_w_src_o  = 1'b1;
        fifo_deq     = 1'b1;
      end
    end
  end

  assign irf_w_data_o = w_data;

  always_comb begin
    hit_any = 1'b0;
    for (int i = 0; i < buf_els_p; i++) begin
      if (slot_v[i] && (slot_tag[i] == check_addr_i)) hit_any = 1'b1;
    end
  end

  assign check_hit_o = hit_any & (check_addr_i != '0) & ~reset_i;

  always_comb begin
    if (!fifo_v || fifo_deq)            starve_cnt_d = '0;
    else if (starve_cnt_q != starve_max_lp) starve_cnt_d = starve_cnt_q + 1'b1;
    else                                starve_cnt_d = starve_cnt_q;
    stall_d = (starve_cnt_d == starve_max_lp);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      starve_cnt_q <= '0;
      stall_q      <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      stall_q      <= stall_d;
    end
  end

  assign stall_o = stall_q & ~reset_i;

endmodule
